// File: rtl/fpmul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpmul_pkg
// Purpose : Shared definitions for the binary32 multiplier round/pack stage:
//           flag-bus bit indices, exception bit indices, FSM state encoding
//           and packed special-value constants.
// Config  : FPMUL_DENORM_EN (consumed by fpmul_round_pack)
// Rev     : 1.0  initial release
// ============================================================================
package fpmul_pkg;

    // Bit positions inside the 12-bit flag bus from the flag generator
    localparam int FLG_AB_DNF    = 0;
    localparam int FLG_AB_ZERO   = 1;
    localparam int FLG_AB_INF    = 2;
    localparam int FLG_AB_NAN    = 3;
    localparam int FLG_OVERFLOW  = 4;
    localparam int FLG_UNDERFLOW = 5;
    localparam int FLG_ROUND     = 6;
    localparam int FLG_MAP_ALL1  = 7;
    localparam int FLG_AP_NANF   = 8;
    localparam int FLG_AP_INFF   = 9;
    localparam int FLG_AP_DNF    = 10;
    localparam int FLG_AP_ZF     = 11;

    // Bit positions inside the 4-bit exception word
    localparam int EXC_INEXACT   = 0;
    localparam int EXC_UNDERFLOW = 1;
    localparam int EXC_OVERFLOW  = 2;
    localparam int EXC_INVALID   = 3;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    // Longest denormalisation shift; beyond this everything is sticky
    localparam logic signed [10:0] SHIFT_CAP = 11'sd25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } fpmul_state_t;

endpackage
`default_nettype wire

// File: rtl/fpmul_rne_inc.sv
`default_nettype none
// ============================================================================
// Module  : fpmul_rne_inc
// Purpose : Combinational round-to-nearest-even increment of a 24-bit
//           significand. Increments when guard is set and either sticky or
//           the LSB is set (ties go to even).
// Ports   : value[23:0] in, guard in, sticky in, sum[23:0] out, carry out
// Rev     : 1.0  initial release
// ============================================================================
module fpmul_rne_inc (
    input  logic [23:0] value,
    input  logic        guard,
    input  logic        sticky,
    output logic [23:0] sum,
    output logic        carry
);
    logic w_inc;

    assign w_inc        = guard & (sticky | value[0]);
    assign {carry, sum} = {1'b0, value} + {24'd0, w_inc};

endmodule
`default_nettype wire

// File: rtl/fpmul_round_pack.sv
`default_nettype none
// ============================================================================
// Module  : fpmul_round_pack
// Purpose : Final stage of the binary32 multiplier. Rounds the product
//           mantissa, handles mantissa carry-out, selects exception results,
//           packs the IEEE-754 word and presents it on a valid/ready port.
//           Keeps a sticky exception status register.
// Ports   : Clk, Rst (async, active-low)
//           in_valid/in_ready, in_sign, in_eap[9:0], in_map[22:0],
//           in_flags[11:0]                     -- operand side
//           out_valid/out_ready, out_result[31:0], out_exc[3:0] -- result
//           status[3:0], status_clr            -- sticky exception status
// Config  : FPMUL_DENORM_EN defined   -> gradual underflow via SHIFT state
//           FPMUL_DENORM_EN undefined -> flush-to-zero
// Rev     : 1.0  initial release
// ============================================================================
module fpmul_round_pack
    import fpmul_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_eap,
    input  logic [22:0] in_map,
    input  logic [11:0] in_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_exc,
    output logic [3:0]  status,
    input  logic        status_clr
);

    fpmul_state_t r_state, w_state_next;

    logic        r_sign;
    logic [9:0]  r_eap;
    logic [22:0] r_map;
    logic [11:0] r_flags;
    logic [31:0] r_result;
    logic [3:0]  r_exc;
    logic [3:0]  r_status;

    logic        w_load_in, w_load_res, w_load_shift, w_to_shift;
    logic        w_round, w_carry, w_ovf, w_unf;
    logic [9:0]  w_exp;
    logic [22:0] w_frac;
    logic [31:0] w_calc_result, w_res_value;
    logic [3:0]  w_calc_exc, w_res_exc;
    logic [23:0] w_rne_value, w_rne_sum;
    logic        w_rne_guard, w_rne_sticky, w_rne_carry;

    // ------------------------------------------------------------------
    // Rounding / exponent adjust for the CALC path
    // ------------------------------------------------------------------
    assign w_round = r_flags[FLG_ROUND];
    // Carry-out is taken from the upstream all-ones flag, not the adder
    assign w_carry = w_round & r_flags[FLG_MAP_ALL1];
    assign w_exp   = r_eap + {9'd0, w_carry};
    assign w_frac  = w_carry ? 23'd0 : w_rne_sum[22:0];
    assign w_ovf   = r_flags[FLG_OVERFLOW] |
                     (~w_exp[9] & (w_exp[8] | (w_exp[7:0] == EXP_MAX)));
    assign w_unf   = r_flags[FLG_UNDERFLOW] | (w_exp == 10'd0);

`ifdef FPMUL_DENORM_EN
    logic [4:0]         r_cnt, w_cnt_init;
    logic [23:0]        r_sh, w_sh_next;
    logic               r_guard, r_sticky, w_g_next, w_s_next;
    logic signed [10:0] w_dist;

    assign w_sh_next = {1'b0, r_sh[23:1]};
    assign w_g_next  = r_sh[0];
    assign w_s_next  = r_sticky | r_guard;

    // Shift distance 1 - exp, held within [1, SHIFT_CAP] so the SHIFT
    // state always runs at least once
    assign w_dist     = 11'sd1 - $signed({r_eap[9], r_eap});
    assign w_cnt_init = (w_dist > SHIFT_CAP) ? 5'd25 :
                        (w_dist < 11'sd1)    ? 5'd1  : w_dist[4:0];

    // The single RNE incrementer serves CALC and the final SHIFT cycle
    assign w_rne_value  = (r_state == ST_SHIFT) ? w_sh_next : {1'b0, r_map};
    assign w_rne_guard  = (r_state == ST_SHIFT) ? w_g_next  : w_round;
    assign w_rne_sticky = (r_state == ST_SHIFT) ? w_s_next  : 1'b1;

    // A rounding carry into bit 23 turns the denormal into exp=1 for free
    assign w_res_value = (r_state == ST_SHIFT) ? {r_sign, 7'd0, w_rne_sum}
                                               : w_calc_result;
    assign w_res_exc   = (r_state == ST_SHIFT)
                         ? {2'b00, w_g_next | w_s_next, w_g_next | w_s_next}
                         : w_calc_exc;
`else
    assign w_rne_value  = {1'b0, r_map};
    assign w_rne_guard  = w_round;
    assign w_rne_sticky = 1'b1;          // forces increment = ROUND
    assign w_res_value  = w_calc_result;
    assign w_res_exc    = w_calc_exc;
`endif

    fpmul_rne_inc u_rne (
        .value  (w_rne_value),
        .guard  (w_rne_guard),
        .sticky (w_rne_sticky),
        .sum    (w_rne_sum),
        .carry  (w_rne_carry)
    );

    // ------------------------------------------------------------------
    // Result select, highest priority first
    // ------------------------------------------------------------------
    always_comb begin
        w_calc_result = {r_sign, w_exp[7:0], w_frac};
        w_calc_exc    = 4'd0;
        w_to_shift    = 1'b0;
        if (r_flags[FLG_AB_NAN]) begin
            w_calc_result            = QNAN;
            w_calc_exc[EXC_INVALID]  = 1'b1;
        end else if (r_flags[FLG_AB_INF]) begin
            w_calc_result = {r_sign, EXP_MAX, 23'd0};
        end else if (r_flags[FLG_AB_ZERO]) begin
            w_calc_result = {r_sign, 31'd0};
`ifndef FPMUL_DENORM_EN
        end else if (r_flags[FLG_AB_DNF]) begin
            w_calc_result              = {r_sign, 31'd0};
            w_calc_exc[EXC_UNDERFLOW]  = 1'b1;
            w_calc_exc[EXC_INEXACT]    = 1'b1;
`endif
        end else if (w_ovf) begin
            w_calc_result             = {r_sign, EXP_MAX, 23'd0};
            w_calc_exc[EXC_OVERFLOW]  = 1'b1;
            w_calc_exc[EXC_INEXACT]   = 1'b1;
        end else if (w_unf) begin
            w_calc_result              = {r_sign, 31'd0};
            w_calc_exc[EXC_UNDERFLOW]  = 1'b1;
            w_calc_exc[EXC_INEXACT]    = 1'b1;
`ifdef FPMUL_DENORM_EN
            w_to_shift                 = 1'b1;
`endif
        end else begin
            w_calc_exc[EXC_INEXACT] = w_round;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_load_in    = 1'b0;
        w_load_res   = 1'b0;
        w_load_shift = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load_in    = 1'b1;
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_to_shift) begin
                    w_load_shift = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_load_res   = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
`ifdef FPMUL_DENORM_EN
            ST_SHIFT: begin
                // The final shift and the rounding share one edge
                if (r_cnt == 5'd1) begin
                    w_load_res   = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_load_in    = 1'b1;
                        w_state_next = ST_CALC;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_sign   <= 1'b0;
            r_eap    <= 10'd0;
            r_map    <= 23'd0;
            r_flags  <= 12'd0;
            r_result <= 32'd0;
            r_exc    <= 4'd0;
        end else begin
            if (w_load_in) begin
                r_sign  <= in_sign;
                r_eap   <= in_eap;
                r_map   <= in_map;
                r_flags <= in_flags;
            end
            if (w_load_res) begin
                r_result <= w_res_value;
                r_exc    <= w_res_exc;
            end
        end
    end

`ifdef FPMUL_DENORM_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_sh     <= 24'd0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= 5'd0;
        end else if (w_load_shift) begin
            r_sh     <= {1'b1, r_map};
            r_guard  <= 1'b0;
            r_sticky <= w_round;       // bits below the mantissa LSB
            r_cnt    <= w_cnt_init;
        end else if (r_state == ST_SHIFT) begin
            r_sh     <= w_sh_next;
            r_guard  <= w_g_next;
            r_sticky <= w_s_next;
            r_cnt    <= r_cnt - 5'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sticky status: a same-cycle set beats the clear for the set bits
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_status <= 4'd0;
        else      r_status <= (status_clr ? 4'd0 : r_status) |
                              (((r_state == ST_HOLD) && out_ready) ? r_exc : 4'd0);
    end

    assign out_result = r_result;
    assign out_exc    = r_exc;
    assign status     = r_status;

    // Operand-class flags are informational here; the incrementer's top
    // bits only matter on the denormal path
    logic w_unused_ok;
    assign w_unused_ok = ^{w_rne_carry, w_rne_sum[23],
                           r_flags[FLG_AP_ZF:FLG_AP_NANF], r_flags[FLG_AB_DNF]};

endmodule
`default_nettype wire
